ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte to the mouse, for example 0xF4 (enable data reporting) or 0xFF (reset). It is the outbound counterpart of the 3-byte mouse packet receiver in the top level, and it drives the shared open-collector PS/2 clock and data lines through output-enables. The block performs the full sequence: clock inhibit, request-to-send, 11-bit shift on device clock edges, ACK check, then line-idle wait.

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_host_tx_if.sv | 10 +
 rtl/ps2_line_sync.sv | 17 +
 rtl/ps2_host_tx.sv | 104 ++++++++++
 tb/tb_ps2_host_tx.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host encodings, command/response bytes and frame builder.
package ps2_pkg;
  localparam logic [2:0] IDLE = 3'd0, INHIBIT = 3'd1, RTS = 3'd2, SHIFT = 3'd3;
  localparam logic [2:0] WAIT_ACK = 3'd4, WAIT_IDLE = 3'd5, DONE = 3'd6;
  localparam logic [7:0] CMD_RESET = 8'hFF, CMD_SET_DEFAULTS = 8'hF6, CMD_ENABLE_REPORT = 8'hF4;
  localparam logic [7:0] RSP_ACK = 8'hFA, RSP_SELFTEST_OK = 8'hAA;
  // {stop, odd parity, data}; bit 0 leaves first
  function automatic logic [9:0] frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake, status and open-collector PS/2 line signals.
interface ps2_host_tx_if;
  logic [7:0] cmd_data;
  logic cmd_valid, cmd_ready, busy, done, ack_ok, timeout_err;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  modport master (output cmd_data, cmd_valid, ps2_clk_in, ps2_data_in,
                  input cmd_ready, busy, done, ack_ok, timeout_err, ps2_clk_oe, ps2_data_oe);
  modport slave (input cmd_data, cmd_valid, ps2_clk_in, ps2_data_in,
                 output cmd_ready, busy, done, ack_ok, timeout_err, ps2_clk_oe, ps2_data_oe);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer for a raw PS/2 line plus falling-edge detector.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic sync,
  output logic fall
);
  logic [2:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[1:0], raw};
  // idle lines float high, so reset to 1 to avoid a spurious fall
  always_ff @(posedge clk or negedge reset)
    if (!reset) sh_q <= 3'b111;
    else sh_q <= sh_d;
  assign sync = sh_q[1];
  assign fall = sh_q[2] & ~sh_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device over PS/2 and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int INHIBIT_CYCLES = CLK_HZ / 10000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 1000 * 15
) (
  input logic            clk,
  input logic            reset,
  ps2_host_tx_if.slave   bus
);
  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [2:0] state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [9:0] sh_q, sh_d;
  logic [1:0] dsync_q, dsync_d;
  logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d, ack_q, ack_d, to_q, to_d;
  logic clk_s, clk_fall, run;
  ps2_line_sync u_clk_sync (.clk(clk), .reset(reset), .raw(bus.ps2_clk_in), .sync(clk_s), .fall(clk_fall));
  assign run = state_q == SHIFT || state_q == WAIT_ACK || state_q == WAIT_IDLE;
  always_comb begin
    dsync_d = {dsync_q[0], bus.ps2_data_in};
    state_d = state_q;
    cnt_d = run ? ((cnt_q == '1) ? cnt_q : cnt_q + 20'd1) : cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    clk_oe_d = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_d = ack_q;
    to_d = to_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        sh_d = frame(bus.cmd_data);
        bit_d = '0;
        cnt_d = '0;
        ack_d = 1'b0;
        to_d = 1'b0;
        clk_oe_d = 1'b1;
        state_d = INHIBIT;
      end
      INHIBIT: begin
        cnt_d = (cnt_q == INH_LAST) ? '0 : cnt_q + 20'd1;
        data_oe_d = cnt_q == INH_LAST;
        state_d = (cnt_q == INH_LAST) ? RTS : INHIBIT;
      end
      RTS: begin
        clk_oe_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: if (clk_fall) begin
        bit_d = bit_q + 4'd1;
        state_d = (bit_q == 4'd10) ? WAIT_ACK : SHIFT;
        data_oe_d = (bit_q == 4'd10) ? data_oe_q : ~sh_q[0];
        sh_d = sh_q >> 1;
      end
      WAIT_ACK: if (clk_fall) begin
        ack_d = ~dsync_q[1];
        state_d = WAIT_IDLE;
      end
      WAIT_IDLE: state_d = (clk_s && dsync_q[1]) ? DONE : WAIT_IDLE;
      default: state_d = IDLE;
    endcase
    // timeout overrides any coincident fall
    if (run && cnt_q == TMO_LAST) begin
      clk_oe_d = 1'b0;
      data_oe_d = 1'b0;
      ack_d = 1'b0;
      to_d = 1'b1;
      state_d = DONE;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      dsync_q <= 2'b11;
      clk_oe_q <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      dsync_q <= dsync_d;
      clk_oe_q <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_q <= ack_d;
      to_q <= to_d;
    end
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.ack_ok = ack_q;
  assign bus.timeout_err = to_q;
  assign bus.ps2_clk_oe = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model driving the shared lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 50, TMO = 1200, HP = 20;
  logic clk = 0, reset = 1;
  logic dev_clk_low = 0, dev_data_low = 0;
  int total = 0, bad = 0, done_cnt = 0;
  int inh, n, d0;
  logic [9:0] got;
  ps2_host_tx_if io();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(io));
  assign io.ps2_clk_in = ~(io.ps2_clk_oe | dev_clk_low);
  assign io.ps2_data_in = ~(io.ps2_data_oe | dev_data_low);
  always #5 clk = ~clk;
  always @(negedge clk) if (io.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    io.cmd_data = d;
    io.cmd_valid = 1;
    @(negedge clk);
    io.cmd_valid = 0;
  endtask

  // accept, count inhibit cycles, stop one cycle into SHIFT
  task automatic start_cmd(input logic [7:0] d, output int cnt);
    int k = 0;
    send(d);
    cnt = 0;
    while (io.ps2_data_oe !== 1'b1 && k < 4 * INH) begin
      k++;
      if (io.ps2_clk_oe === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("rts_clk_oe", io.ps2_clk_oe, 1);
    chk("rts_start_bit", io.ps2_data_oe, 1);
    @(negedge clk);
    chk("shift_clk_released", io.ps2_clk_oe, 0);
  endtask

  // device clocks npulse times, samples on rising edges, optionally ACKs
  task automatic dev_xfer(input int npulse, input bit ack, input bit inj, output logic [9:0] bits);
    bits = '0;
    for (int k = 0; k < npulse; k++) begin
      repeat (HP) @(negedge clk);
      dev_clk_low = 1;
      if (inj && k == 4) begin
        io.cmd_data = 8'h55;
        io.cmd_valid = 1;
      end
      @(negedge clk);
      io.cmd_valid = 0;
      repeat (HP - 1) @(negedge clk);
      dev_clk_low = 0;
      if (k < 10) bits[k] = io.ps2_data_in;
      if (k == 9) dev_data_low = ack;
      if (k == 11) dev_data_low = 0;
    end
  endtask

  task automatic wait_done(input int lim, output int cnt);
    cnt = 0;
    while (io.done !== 1'b1 && cnt < lim) begin
      @(negedge clk);
      cnt++;
    end
    chk("done_seen", io.done, 1);
  endtask

  initial begin
    io.cmd_valid = 0;
    io.cmd_data = 0;
    #1 reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", io.cmd_ready, 1);
    chk("rst_busy", io.busy, 0);
    chk("rst_done", io.done, 0);
    chk("rst_ack", io.ack_ok, 0);
    chk("rst_timeout", io.timeout_err, 0);
    chk("rst_clk_oe", io.ps2_clk_oe, 0);
    chk("rst_data_oe", io.ps2_data_oe, 0);
    reset = 1;
    @(negedge clk);

    // 1: 0xF4 with ACK
    d0 = done_cnt;
    start_cmd(CMD_ENABLE_REPORT, inh);
    chk("t1_inhibit_len", inh, INH);
    dev_xfer(12, 1, 0, got);
    wait_done(100, n);
    chk("t1_frame", got, 10'h2F4);
    chk("t1_ack", io.ack_ok, 1);
    chk("t1_timeout", io.timeout_err, 0);
    chk("t1_clk_oe", io.ps2_clk_oe, 0);
    chk("t1_data_oe", io.ps2_data_oe, 0);
    chk("t1_busy_in_done", io.busy, 1);
    chk("t1_ready_in_done", io.cmd_ready, 0);
    @(negedge clk);
    chk("t1_ready_after", io.cmd_ready, 1);
    chk("t1_done_low", io.done, 0);
    chk("t1_ack_hold", io.ack_ok, 1);
    chk("t1_done_pulses", done_cnt - d0, 1);

    // 2: 0x00 back-to-back, parity 1
    start_cmd(8'h00, inh);
    chk("t2_inhibit_len", inh, INH);
    chk("t2_ack_cleared", io.ack_ok, 0);
    dev_xfer(12, 1, 0, got);
    wait_done(100, n);
    chk("t2_frame", got, 10'h300);
    chk("t2_ack", io.ack_ok, 1);
    @(negedge clk);

    // 3: 0xF6, device leaves data high at ACK
    start_cmd(CMD_SET_DEFAULTS, inh);
    dev_xfer(12, 0, 0, got);
    wait_done(100, n);
    chk("t3_frame", got, 10'h3F6);
    chk("t3_ack", io.ack_ok, 0);
    chk("t3_timeout", io.timeout_err, 0);
    chk("t3_clk_oe", io.ps2_clk_oe, 0);
    chk("t3_data_oe", io.ps2_data_oe, 0);
    @(negedge clk);

    // 4: device silent after RTS -> timeout
    start_cmd(CMD_ENABLE_REPORT, inh);
    wait_done(TMO + 20, n);
    chk("t4_timeout_cycles", n, TMO);
    chk("t4_timeout", io.timeout_err, 1);
    chk("t4_ack", io.ack_ok, 0);
    chk("t4_clk_oe", io.ps2_clk_oe, 0);
    chk("t4_data_oe", io.ps2_data_oe, 0);
    @(negedge clk);
    chk("t4_ready_next", io.cmd_ready, 1);
    chk("t4_timeout_hold", io.timeout_err, 1);

    // 5a: reset during INHIBIT drops clk_oe without a clock edge
    send(CMD_RESET);
    repeat (5) @(negedge clk);
    chk("t5a_clk_oe_pre", io.ps2_clk_oe, 1);
    #1 reset = 0;
    #1;
    chk("t5a_clk_oe_async", io.ps2_clk_oe, 0);
    chk("t5a_busy_async", io.busy, 0);
    chk("t5a_timeout_cleared", io.timeout_err, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    // 5b: reset after the 4th fall of 0xFF
    start_cmd(CMD_RESET, inh);
    dev_xfer(3, 1, 0, got);
    repeat (HP) @(negedge clk);
    dev_clk_low = 1;
    repeat (10) @(negedge clk);
    chk("t5b_busy_pre", io.busy, 1);
    #1 reset = 0;
    #1;
    chk("t5b_clk_oe_async", io.ps2_clk_oe, 0);
    chk("t5b_data_oe_async", io.ps2_data_oe, 0);
    chk("t5b_busy_async", io.busy, 0);
    dev_clk_low = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("t5b_ready", io.cmd_ready, 1);
    chk("t5b_busy", io.busy, 0);

    // 6: cmd_valid 0x55 during SHIFT of 0xF4 is ignored
    d0 = done_cnt;
    start_cmd(CMD_ENABLE_REPORT, inh);
    dev_xfer(12, 1, 1, got);
    wait_done(100, n);
    chk("t6_frame", got, 10'h2F4);
    chk("t6_ack", io.ack_ok, 1);
    repeat (INH + 10) @(negedge clk);
    chk("t6_no_second_cmd", io.busy, 0);
    chk("t6_clk_oe_idle", io.ps2_clk_oe, 0);
    chk("t6_done_pulses", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
